// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The op and state encodings live as defines so that non-package code can
// reuse them; the package wraps them in typed enums for the RTL.
`ifndef MULDIV_UNIT_DEFS_SVH
`define MULDIV_UNIT_DEFS_SVH
`define MD_OP_MUL     3'b000
`define MD_OP_MULH    3'b001
`define MD_OP_MULHSU  3'b010
`define MD_OP_MULHU   3'b011
`define MD_OP_DIV     3'b100
`define MD_OP_DIVU    3'b101
`define MD_OP_REM     3'b110
`define MD_OP_REMU    3'b111
`define MD_ST_IDLE    2'd0
`define MD_ST_BUSY    2'd1
`define MD_ST_DONE    2'd2
`endif

package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = `MD_OP_MUL,
    OP_MULH   = `MD_OP_MULH,
    OP_MULHSU = `MD_OP_MULHSU,
    OP_MULHU  = `MD_OP_MULHU,
    OP_DIV    = `MD_OP_DIV,
    OP_DIVU   = `MD_OP_DIVU,
    OP_REM    = `MD_OP_REM,
    OP_REMU   = `MD_OP_REMU
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = `MD_ST_IDLE,
    ST_BUSY = `MD_ST_BUSY,
    ST_DONE = `MD_ST_DONE
  } md_state_e;

  // rs1 is signed for MUL/MULH/MULHSU and DIV/REM
  function automatic logic op_signed_a(input logic [2:0] op);
    return op[2] ? ~op[0] : (op != OP_MULHU);
  endfunction

  // rs2 is signed for MUL/MULH and DIV/REM
  function automatic logic op_signed_b(input logic [2:0] op);
    return op[2] ? ~op[0] : ~op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration on unsigned magnitudes.
// Multiply: {hi,lo} is the running product, lo holds the unused multiplier
// bits; add opnd into hi when lo[0] is set, then shift the pair right.
// Divide: {hi,lo} is {partial remainder, dividend/quotient}; shift left one,
// trial-subtract the divisor and keep the result if it did not borrow.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] sub_diff;

  assign add_sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
  assign shifted  = {hi_i, lo_i[WIDTH-1]};
  assign sub_diff = shifted - {1'b0, opnd_i};

  // Select the multiply or restoring-divide update for this iteration
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (is_div_i) begin
      // remainder < divisor, so a non-borrowing difference fits WIDTH bits
      if (!sub_diff[WIDTH]) begin
        hi_o = sub_diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = add_sum[WIDTH:1];
      lo_o = {add_sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit with valid/ready handshakes.
// Normal ops run WIDTH radix-2 iterations on magnitudes and fix the sign at
// the end; divide-by-zero and signed overflow complete immediately.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zflag
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q, result_q;
  logic [2:0]       op_q;
  logic             neg_q, out_valid_q, in_ready_q;

  logic [WIDTH-1:0] step_hi, step_lo;

  // Request decode: operand signs, magnitudes and the short-circuit cases
  logic             sa, sb, div_zero, div_ovf, neg_d;
  logic [WIDTH-1:0] mag_a, mag_b, special_res;

  always_comb begin
    sa          = op_signed_a(op) & a[WIDTH-1];
    sb          = op_signed_b(op) & b[WIDTH-1];
    mag_a       = sa ? -a : a;
    mag_b       = sb ? -b : b;
    // remainder follows the dividend; everything else follows sign xor
    neg_d       = (op == OP_REM) ? sa : (sa ^ sb);
    div_zero    = op[2] && (b == '0);
    div_ovf     = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    special_res = '0;
    if (div_zero)     special_res = op[1] ? a : '1;
    else if (div_ovf) special_res = op[1] ? '0 : a;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Final sign correction and half/quotient/remainder selection
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   dv, dv_fix, fin;

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    dv       = op_q[1] ? step_hi : step_lo;
    dv_fix   = neg_q ? -dv : dv;
    if (op_q[2])              fin = dv_fix;
    else if (op_q[1:0] == '0) fin = prod_fix[WIDTH-1:0];
    else                      fin = prod_fix[2*WIDTH-1:WIDTH];
  end

  // Control FSM with datapath registers; rst beats flush beats handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= op;
            neg_q      <= neg_d;
            cnt_q      <= '0;
            hi_q       <= '0;
            in_ready_q <= 1'b0;
            // multiply iterates over rs2 bits; divide shifts the dividend out
            lo_q       <= op[2] ? mag_a : mag_b;
            opnd_q     <= op[2] ? mag_b : mag_a;
            if (div_zero || div_ovf) begin
              state_q     <= ST_DONE;
              result_q    <= special_res;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= ST_DONE;
            result_q    <= fin;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_valid_q && out_ready) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          result_q    <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zflag     = (result_q == '0);

endmodule
